// File: rtl/datapath_pkg.sv
// Shared types and sizing for the FU issue scheduler: row state encoding,
// the per-row FUST record and the tag wakeup helper.
package datapath_pkg;

   localparam int NUM_FU = 5;
   localparam int TAG_W  = 3;
   localparam int FU_W   = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      READY = 2'd2,
      EXEC  = 2'd3
   } fust_state_e;

   typedef struct packed {
      fust_state_e      state;
      logic [TAG_W-1:0] t1;
      logic [TAG_W-1:0] t2;
      logic             spec;
   } sched_row_t;

   // Tag k names FU k-1, so a broadcast from wb_fu satisfies tag wb_fu+1.
   function automatic logic [TAG_W-1:0] wake_tag(input logic [TAG_W-1:0] tag,
                                                 input logic             wb_valid,
                                                 input logic [FU_W-1:0]  wb_fu);
      return (wb_valid && tag == TAG_W'(wb_fu) + TAG_W'(1)) ? '0 : tag;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 gnt_valid,
   output logic [$clog2(N)-1:0] gnt_idx
);

   localparam int PW = $clog2(N);

   // Walk offsets from farthest to nearest so the closest request overwrites.
   always_comb begin
      // NOTE: every output gets a default before the loop so no latch is inferred.
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      for (int off = N - 1; off >= 0; off--) begin
         if (req[(int'(ptr) + off) % N]) begin
            gnt_valid = 1'b1;
            gnt_idx   = PW'((int'(ptr) + off) % N);
         end
      end
   end

endmodule

// File: rtl/fu_issue_scheduler.sv
// Issue-stage FUST scheduler: allocation, tag wakeup, mispredict squash and a
// single round-robin issue grant per cycle.
module fu_issue_scheduler
   import datapath_pkg::*;
(
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  alloc_en,
   input  logic [FU_W-1:0]       alloc_fu,
   input  logic [TAG_W-1:0]      alloc_t1,
   input  logic [TAG_W-1:0]      alloc_t2,
   input  logic                  alloc_spec,
   output logic                  alloc_err,
   input  logic                  wb_valid,
   input  logic [FU_W-1:0]       wb_fu,
   input  logic                  branch_resolved,
   input  logic                  branch_miss,
   input  logic                  freeze,
   output logic                  issue_valid,
   output logic [FU_W-1:0]       issue_fu,
   output logic [2*NUM_FU-1:0]   fu_state,
   output logic [NUM_FU-1:0]     fu_idle
);

   sched_row_t          rows_q [NUM_FU];
   sched_row_t          rows_d [NUM_FU];
   logic [FU_W-1:0]     rr_ptr;
   logic [NUM_FU-1:0]   ready_vec;
   logic [NUM_FU-1:0]   idle_vec;
   logic [NUM_FU-1:0]   alloc_hit;
   logic                gnt_valid;
   logic [FU_W-1:0]     gnt_idx;
   logic                grant;
   logic                mispredict;
   logic                alloc_drop;
   logic                alloc_err_d;

   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         ready_vec[i]         = (rows_q[i].state == READY);
         idle_vec[i]          = (rows_q[i].state == IDLE);
         fu_state[2*i +: 2]   = rows_q[i].state;
      end
   end

   rr_arbiter #(.N(NUM_FU)) u_issue_arb (
      .req       (ready_vec),
      .ptr       (rr_ptr),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // A speculative alloc racing a mispredict is already on the wrong path.
   always_comb begin
      mispredict  = branch_resolved & branch_miss;
      alloc_drop  = alloc_en & alloc_spec & mispredict;
      grant       = gnt_valid & ~freeze;
      for (int i = 0; i < NUM_FU; i++) begin
         alloc_hit[i] = alloc_en && !alloc_drop && (alloc_fu == FU_W'(i));
      end
      alloc_err_d = alloc_en & ~alloc_drop & ~(|(alloc_hit & idle_vec));

      for (int i = 0; i < NUM_FU; i++) begin
         rows_d[i]      = rows_q[i];
         rows_d[i].t1   = wake_tag(rows_q[i].t1, wb_valid, wb_fu);
         rows_d[i].t2   = wake_tag(rows_q[i].t2, wb_valid, wb_fu);
         rows_d[i].spec = rows_q[i].spec & ~branch_resolved;

         case (rows_q[i].state)
            IDLE: begin
               if (alloc_hit[i]) begin
                  rows_d[i].t1    = wake_tag(alloc_t1, wb_valid, wb_fu);
                  rows_d[i].t2    = wake_tag(alloc_t2, wb_valid, wb_fu);
                  rows_d[i].spec  = alloc_spec;
                  rows_d[i].state = (rows_d[i].t1 == '0 && rows_d[i].t2 == '0) ? READY : WAIT;
               end
            end
            WAIT: begin
               if (rows_d[i].t1 == '0 && rows_d[i].t2 == '0) rows_d[i].state = READY;
            end
            READY: begin
               if (grant && gnt_idx == FU_W'(i)) rows_d[i].state = EXEC;
            end
            EXEC: begin
               if (wb_valid && wb_fu == FU_W'(i)) rows_d[i].state = IDLE;
            end
            default: rows_d[i].state = IDLE;
         endcase

         // Squash only rows still waiting to issue; a same-cycle grant is kept.
         if (mispredict && rows_q[i].spec &&
             (rows_q[i].state == WAIT ||
              (rows_q[i].state == READY && !(grant && gnt_idx == FU_W'(i))))) begin
            rows_d[i] = '{state: IDLE, t1: '0, t2: '0, spec: 1'b0};
         end
      end
   end

   // NOTE: the row table is only NUM_FU entries, so it is reset like ordinary state.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < NUM_FU; i++) begin
            rows_q[i] <= '{state: IDLE, t1: '0, t2: '0, spec: 1'b0};
         end
         rr_ptr      <= '0;
         issue_valid <= 1'b0;
         issue_fu    <= '0;
         alloc_err   <= 1'b0;
         fu_idle     <= '1;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         rows_q      <= rows_d;
         issue_valid <= grant;
         alloc_err   <= alloc_err_d;
         for (int i = 0; i < NUM_FU; i++) begin
            fu_idle[i] <= (rows_d[i].state == IDLE);
         end
         if (grant) begin
            issue_fu <= gnt_idx;
            rr_ptr   <= (gnt_idx == FU_W'(NUM_FU - 1)) ? '0 : gnt_idx + FU_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Directed-vector bench for fu_issue_scheduler with hand-computed expectations.
module tb_fu_issue_scheduler;
   import datapath_pkg::*;

   logic                 CLK;
   logic                 nRST;
   logic                 alloc_en;
   logic [FU_W-1:0]      alloc_fu;
   logic [TAG_W-1:0]     alloc_t1;
   logic [TAG_W-1:0]     alloc_t2;
   logic                 alloc_spec;
   logic                 alloc_err;
   logic                 wb_valid;
   logic [FU_W-1:0]      wb_fu;
   logic                 branch_resolved;
   logic                 branch_miss;
   logic                 freeze;
   logic                 issue_valid;
   logic [FU_W-1:0]      issue_fu;
   logic [2*NUM_FU-1:0]  fu_state;
   logic [NUM_FU-1:0]    fu_idle;

   int n_vec  = 0;
   int n_miss = 0;

   fu_issue_scheduler dut (
      .CLK             (CLK),
      .nRST            (nRST),
      .alloc_en        (alloc_en),
      .alloc_fu        (alloc_fu),
      .alloc_t1        (alloc_t1),
      .alloc_t2        (alloc_t2),
      .alloc_spec      (alloc_spec),
      .alloc_err       (alloc_err),
      .wb_valid        (wb_valid),
      .wb_fu           (wb_fu),
      .branch_resolved (branch_resolved),
      .branch_miss     (branch_miss),
      .freeze          (freeze),
      .issue_valid     (issue_valid),
      .issue_fu        (issue_fu),
      .fu_state        (fu_state),
      .fu_idle         (fu_idle)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [1:0] st(input int i);
      return fu_state[2*i +: 2];
   endfunction

   task automatic idle_in();
      alloc_en = 1'b0; alloc_fu = '0; alloc_t1 = '0; alloc_t2 = '0; alloc_spec = 1'b0;
      wb_valid = 1'b0; wb_fu = '0;
      branch_resolved = 1'b0; branch_miss = 1'b0; freeze = 1'b0;
   endtask

   task automatic do_alloc(input logic [FU_W-1:0] fu, input logic [TAG_W-1:0] t1,
                           input logic [TAG_W-1:0] t2, input logic spec);
      alloc_en = 1'b1; alloc_fu = fu; alloc_t1 = t1; alloc_t2 = t2; alloc_spec = spec;
   endtask

   task automatic do_wb(input logic [FU_W-1:0] fu);
      wb_valid = 1'b1; wb_fu = fu;
   endtask

   // Apply the current inputs across one edge, then return to quiet inputs.
   task automatic tick();
      @(posedge CLK);
      #1;
      idle_in();
   endtask

   initial begin
      idle_in();
      nRST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_state",   32'(fu_state),    32'h0);
      check("rst_idle",    32'(fu_idle),     32'h1f);
      check("rst_ivalid",  32'(issue_valid), 32'h0);
      check("rst_ifu",     32'(issue_fu),    32'h0);
      check("rst_err",     32'(alloc_err),   32'h0);
      nRST = 1'b1;

      // Independent allocations, RR ptr ends at 3.
      do_alloc(0, 0, 0, 0); tick();
      check("ind_st0_ready", 32'(st(0)), 32'd2);
      check("ind_idle",      32'(fu_idle), 32'h1e);
      check("ind_no_issue",  32'(issue_valid), 32'h0);
      do_alloc(2, 0, 0, 0); tick();
      check("ind_iv0",     32'(issue_valid), 32'h1);
      check("ind_ifu0",    32'(issue_fu), 32'd0);
      check("ind_st0_exec",32'(st(0)), 32'd3);
      check("ind_st2_rdy", 32'(st(2)), 32'd2);
      tick();
      check("ind_iv2",     32'(issue_valid), 32'h1);
      check("ind_ifu2",    32'(issue_fu), 32'd2);
      tick();
      check("ind_quiet",   32'(issue_valid), 32'h0);

      // Dependency on FU0, woken by its writeback.
      do_alloc(1, 1, 0, 0); tick();
      check("dep_wait",    32'(st(1)), 32'd1);
      tick();
      check("dep_hold",    32'(st(1)), 32'd1);
      do_wb(0); tick();
      check("dep_fu0_idle",32'(st(0)), 32'd0);
      check("dep_ready",   32'(st(1)), 32'd2);
      check("dep_no_iv",   32'(issue_valid), 32'h0);
      tick();
      check("dep_iv",      32'(issue_valid), 32'h1);
      check("dep_ifu",     32'(issue_fu), 32'd1);

      // Bypass: tag 2 satisfied by the same-cycle wb of FU1.
      do_alloc(3, 0, 2, 0); do_wb(1); tick();
      check("byp_ready",   32'(st(3)), 32'd2);
      check("byp_fu1_idle",32'(st(1)), 32'd0);
      tick();
      check("byp_ifu",     32'(issue_fu), 32'd3);
      check("byp_exec",    32'(st(3)), 32'd3);
      do_wb(2); tick();
      do_wb(3); tick();
      check("byp_all_idle",32'(fu_idle), 32'h1f);

      // Freeze with ready rows; RR ptr 4 wraps to FU0 first.
      freeze = 1'b1; do_alloc(0, 0, 0, 0); tick();
      check("frz_iv_a",    32'(issue_valid), 32'h0);
      freeze = 1'b1; do_alloc(1, 0, 0, 0); tick();
      check("frz_iv_b",    32'(issue_valid), 32'h0);
      freeze = 1'b1; tick();
      check("frz_iv_c",    32'(issue_valid), 32'h0);
      check("frz_st0",     32'(st(0)), 32'd2);
      check("frz_st1",     32'(st(1)), 32'd2);
      tick();
      check("frz_rel_iv",  32'(issue_valid), 32'h1);
      check("frz_rel_fu",  32'(issue_fu), 32'd0);
      tick();
      check("frz_next_fu", 32'(issue_fu), 32'd1);

      // Allocation errors.
      do_alloc(0, 0, 0, 0); tick();
      check("err_busy",    32'(alloc_err), 32'h1);
      check("err_st0",     32'(st(0)), 32'd3);
      tick();
      check("err_pulse",   32'(alloc_err), 32'h0);
      do_alloc(5, 0, 0, 0); tick();
      check("err_range",   32'(alloc_err), 32'h1);
      do_alloc(1, 0, 0, 0); do_wb(1); tick();
      check("err_wb_same", 32'(alloc_err), 32'h1);
      check("err_wb_st1",  32'(st(1)), 32'd0);
      check("err_wb_idle", 32'(fu_idle[1]), 32'h1);
      do_wb(0); tick();
      check("err_clear",   32'(alloc_err), 32'h0);
      check("err_all_idle",32'(fu_idle), 32'h1f);

      // Mispredict: spec FU2 in EXEC survives, spec FU4 in WAIT squashed.
      do_alloc(2, 0, 0, 1); tick();
      check("mp_st2_rdy",  32'(st(2)), 32'd2);
      do_alloc(4, 3, 0, 1); tick();
      check("mp_ifu2",     32'(issue_fu), 32'd2);
      check("mp_st4_wait", 32'(st(4)), 32'd1);
      branch_resolved = 1'b1; branch_miss = 1'b1; do_alloc(0, 0, 0, 0); tick();
      check("mp_st4_idle", 32'(st(4)), 32'd0);
      check("mp_st2_exec", 32'(st(2)), 32'd3);
      check("mp_nonspec",  32'(st(0)), 32'd2);
      check("mp_no_err",   32'(alloc_err), 32'h0);
      branch_resolved = 1'b1; branch_miss = 1'b1; do_alloc(1, 0, 0, 1); tick();
      check("mp_drop_st1", 32'(st(1)), 32'd0);
      check("mp_drop_err", 32'(alloc_err), 32'h0);
      check("mp_ifu0",     32'(issue_fu), 32'd0);
      do_wb(2); tick();
      check("mp_st2_drain",32'(st(2)), 32'd0);
      do_wb(0); tick();

      // Grant wins over a same-cycle squash (RR ptr 1 reaches FU3).
      do_alloc(3, 0, 0, 1); tick();
      branch_resolved = 1'b1; branch_miss = 1'b1; tick();
      check("gw_st3_exec", 32'(st(3)), 32'd3);
      check("gw_ifu3",     32'(issue_fu), 32'd3);

      // Correct prediction clears spec, so a later miss leaves FU4 alone.
      do_alloc(4, 4, 0, 1); tick();
      check("cp_wait",     32'(st(4)), 32'd1);
      branch_resolved = 1'b1; tick();
      branch_resolved = 1'b1; branch_miss = 1'b1; tick();
      check("cp_kept",     32'(st(4)), 32'd1);
      do_wb(3); tick();
      check("cp_ready",    32'(st(4)), 32'd2);
      check("cp_st3_idle", 32'(st(3)), 32'd0);
      tick();
      check("cp_ifu4",     32'(issue_fu), 32'd4);
      check("cp_exec",     32'(st(4)), 32'd3);

      // Asynchronous reset mid-cycle with a row in EXEC.
      #2;
      nRST = 1'b0;
      #1;
      check("arst_state",  32'(fu_state),    32'h0);
      check("arst_iv",     32'(issue_valid), 32'h0);
      check("arst_idle",   32'(fu_idle),     32'h1f);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/fu_issue_scheduler.md
Name: fu_issue_scheduler

Overview:
- Issue-stage scheduler for the five functional-unit status (FUST) rows: scalar ALU, scalar ld/st, branch, matrix ld/st, GEMM.
- Tracks per-FU state and operand-dependency tags, wakes waiting rows on writeback broadcasts, and squashes speculative rows on branch mispredict.
- Grants at most one FU per cycle to execute, using round-robin arbitration.
- Sits between dispatch (allocation) and execute (issue grant); its state vector drives the issue-stage fust_state outputs.

Parameters:
NUM_FU, 5, number of functional units / FUST rows
TAG_W, 3, dependency tag width; 0 = operand ready, k = waiting on FU k-1
FU_W, 3, width of an FU index

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
alloc_en  input  1  dispatch writes a row this cycle
alloc_fu  input  FU_W  target row index
alloc_t1  input  TAG_W  source-1 producer tag
alloc_t2  input  TAG_W  source-2 producer tag
alloc_spec  input  1  instruction dispatched under an unresolved branch
alloc_err  output  1  registered pulse: alloc to a non-IDLE row, or alloc_fu >= NUM_FU
wb_valid  input  1  FU completion broadcast
wb_fu  input  FU_W  completing FU index
branch_resolved  input  1  oldest branch resolved this cycle
branch_miss  input  1  qualifies branch_resolved: mispredict
freeze  input  1  stall issue
issue_valid  output  1  registered grant valid
issue_fu  output  FU_W  registered granted FU index
fu_state  output  NUM_FU x 2  per-row state (IDLE=0, WAIT=1, READY=2, EXEC=3)
fu_idle  output  NUM_FU  row is IDLE; dispatch back-pressure

Behaviour:
Reset:
- All rows IDLE; tags 0; spec bits 0; RR pointer 0.
- issue_valid=0, issue_fu=0, alloc_err=0, fu_idle=all ones.

Allocation (alloc_en, row IDLE):
- Bypass first: a tag equal to wb_fu+1 while wb_valid=1 is stored as 0.
- If both stored tags are 0, row goes READY next cycle; otherwise WAIT.
- spec bit is latched from alloc_spec.
- Alloc to a non-IDLE row, or alloc_fu >= NUM_FU: row unchanged, alloc_err=1 next cycle.

Wakeup (wb_valid):
- Every row's t1/t2 equal to wb_fu+1 clears to 0 at the edge.
- A WAIT row whose tags are both 0 after the edge becomes READY one cycle later (state is registered).
- Row wb_fu: EXEC->IDLE. wb to a row not in EXEC is ignored for that row's state, but the wakeup broadcast still applies.

Selection:
- Candidates are rows registered READY. Search starts at the RR pointer and proceeds upward with wrap-around.
- If freeze=0 and a candidate exists, the winner goes READY->EXEC at the edge, and issue_valid=1 / issue_fu=winner the next cycle.
- RR pointer advances to winner+1 mod NUM_FU.
- Latency: READY at cycle N -> issue_valid at N+1. wb at N -> dependent issue_valid at N+2 at the earliest.

Freeze:
- No grant; issue_valid=0 next cycle; RR pointer holds.
- Allocation, wakeup, writeback and branch handling continue.

Branch handling:
- branch_resolved & ~branch_miss: all spec bits clear.
- branch_resolved & branch_miss:
  - Spec rows in WAIT/READY go IDLE.
  - Spec rows in EXEC stay EXEC, spec cleared; they drain via wb.
  - An alloc_spec=1 in the same cycle is dropped silently (no alloc_err).
  - A non-spec alloc in the same cycle proceeds.
- A row granted in the same cycle as a mispredict is not squashed (grant wins).

Simultaneous events:
- alloc and wb to the same row in one cycle: wb applies only if the row is EXEC. Since alloc requires IDLE, the alloc errors.
- A row freed by wb cannot be re-allocated until the next cycle (fu_idle is registered).
- Outputs are glitch-free registered, except fu_state, which is the direct state register.

Decomposition:
- datapath_pkg: fust_state_e (IDLE/WAIT/READY/EXEC), NUM_FU, FU_W, TAG_W constants, and a sched_row_t struct {state, t1, t2, spec}.
- Sub-module rr_arbiter: parameter N; inputs req[N], ptr; outputs gnt_valid and gnt_idx. Purely combinational, reused by the writeback arbiter.

Test Plan:
- Reset: assert nRST=0 mid-operation with rows in EXEC -> all fu_state=IDLE, issue_valid=0, fu_idle=5'b11111 immediately.
- Independent allocs: FU0 and FU2 with tags 0 at cycle 0 -> issue_fu=0 at cycle 2, issue_fu=2 at cycle 3, RR pointer=3.
- Dependency:
  - FU1 allocated with t1=1 (waits on FU0) while FU0 is EXEC.
  - wb_fu=0 at cycle 5 -> FU1 READY at cycle 6, issue_valid/issue_fu=1 at cycle 7.
- Bypass: alloc FU3 with t2=2 in the same cycle as wb_fu=1 -> FU3 READY next cycle, no WAIT.
- Mispredict: spec FU4 in WAIT and spec FU2 in EXEC, branch_resolved=branch_miss=1 -> FU4 IDLE; FU2 stays EXEC and goes IDLE on its wb.
- Freeze and error:
  - freeze=1 for 3 cycles with FU0 READY -> no issue; issue_fu=0 the cycle after freeze drops.
  - alloc to EXEC FU0 -> alloc_err pulse for 1 cycle, FU0 unchanged.
